// File: rtl/mul16_seq_ctrl.sv
// mul16_seq_ctrl: sequential shift-and-add unsigned multiplier controller.
// Reuses one external WIDTH-bit adder for WIDTH iterations and produces a
// 2*WIDTH-bit product with a start/busy/done handshake.
// Optional feature: define MUL_OVF_EN to add the registered ovf output, set
// when the product does not fit in WIDTH bits.

module mul16_seq_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
`ifdef MUL_OVF_EN
  ,
  output logic               ovf
`endif
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   p_next;
  logic                 last_iter;

`ifdef MUL_OVF_EN
  logic ovf_q, ovf_d;
`endif

  // Shifted partial product: the adder carry lands in the MSB so nothing is lost.
  assign p_next    = {add_cout, add_sum, p_q[WIDTH-1:1]};
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // Next-state, datapath update and adder operand drive.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
`ifdef MUL_OVF_EN
    ovf_d     = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d = a;
          p_d     = {{WIDTH{1'b0}}, b};
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        add_a = p_q[2*WIDTH-1:WIDTH];
        add_b = p_q[0] ? mcand_q : '0;
        p_d   = p_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          product_d = p_next;
          done_d    = 1'b1;
          state_d   = StDone;
`ifdef MUL_OVF_EN
          ovf_d     = |p_next[2*WIDTH-1:WIDTH];
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

`ifdef MUL_OVF_EN
  // Overflow flag, updated together with product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// Self-checking bench for mul16_seq_ctrl with a behavioural model of the
// external adder. Directed vectors with hand-computed products.

module tb_mul16_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic [15:0] add_sum;
  logic        add_cout;
`ifdef MUL_OVF_EN
  logic        ovf;
`endif

  int n_checks;
  int n_fail;
  int lat;
  int busy_cnt;
  int n_done;
  bit addb_nz;
  bit cin_nz;

  mul16_seq_ctrl #(
    .WIDTH(16),
    .CNT_W(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_cin (add_cin),
    .add_sum (add_sum),
    .add_cout(add_cout)
`ifdef MUL_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  // External 16-bit adder model.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one accept edge; returns one cycle into CALC.
  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_v);
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done, counting cycles since accept and busy cycles.
  task automatic wait_done(output int l, output int bc);
    l       = 1;
    bc      = 0;
    addb_nz = 1'b0;
    cin_nz  = 1'b0;
    while (1) begin
      if (busy) bc++;
      if (add_b != 16'd0) addb_nz = 1'b1;
      if (add_cin) cin_nz = 1'b1;
      if (done || l >= 40) break;
      @(negedge clk);
      l++;
    end
  endtask

  logic [31:0] b2b_exp [3];
  logic [15:0] b2b_a   [3];
  logic [15:0] b2b_b   [3];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    b2b_a[0] = 16'h0010; b2b_b[0] = 16'h0011; b2b_exp[0] = 32'h0000_0110;
    b2b_a[1] = 16'hABCD; b2b_b[1] = 16'h1234; b2b_exp[1] = 32'h0C37_4FA4;
    b2b_a[2] = 16'h8000; b2b_b[2] = 16'h0002; b2b_exp[2] = 32'h0001_0000;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_product", product, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_add_a", add_a, 0);
    check_eq("rst_add_b", add_b, 0);
`ifdef MUL_OVF_EN
    check_eq("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;

    // 3 x 5: latency and busy length
    start_op(16'h0003, 16'h0005);
    wait_done(lat, busy_cnt);
    check_eq("t1_latency", lat, 17);
    check_eq("t1_busy_cycles", busy_cnt, 17);
    check_eq("t1_product", product, 32'h0000_000F);
    check_eq("t1_add_a_done", add_a, 0);
    check_eq("t1_add_cin", cin_nz, 0);
`ifdef MUL_OVF_EN
    check_eq("t1_ovf", ovf, 0);
`endif
    @(negedge clk);
    check_eq("t1_done_single", done, 0);
    check_eq("t1_busy_idle", busy, 0);

    // FFFF x FFFF: carry captured every iteration
    start_op(16'hFFFF, 16'hFFFF);
    wait_done(lat, busy_cnt);
    check_eq("t2_latency", lat, 17);
    check_eq("t2_product", product, 32'hFFFE_0001);
`ifdef MUL_OVF_EN
    check_eq("t2_ovf", ovf, 1);
`endif

    // 1234 x 0: full latency, add_b never driven
    start_op(16'h1234, 16'h0000);
    wait_done(lat, busy_cnt);
    check_eq("t3_latency", lat, 17);
    check_eq("t3_product", product, 0);
    check_eq("t3_add_b_zero", addb_nz, 0);
`ifdef MUL_OVF_EN
    check_eq("t3_ovf", ovf, 0);
`endif

    // 2 x 3 with start pulses during CALC and DONE that must be ignored
    start_op(16'h0002, 16'h0003);
    n_done = 0;
    for (int k = 1; k <= 25; k++) begin
      if (done) n_done++;
      if (k == 5 || done) begin
        start = 1'b1;
        a     = 16'h7777;
        b     = 16'h7777;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("t4_done_count", n_done, 1);
    check_eq("t4_product", product, 32'h0000_0006);
    check_eq("t4_busy_idle", busy, 0);

    // Reset mid-operation
    start_op(16'h00FF, 16'h00FF);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_product", product, 0);
    check_eq("t5_rst_done", done, 0);
    check_eq("t5_rst_busy", busy, 0);
    @(negedge clk);
    rst    = 1'b0;
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      if (done || busy) n_done++;
      @(negedge clk);
    end
    check_eq("t5_no_done_after_rst", n_done, 0);
    start_op(16'h0100, 16'h0100);
    wait_done(lat, busy_cnt);
    check_eq("t5_latency", lat, 17);
    check_eq("t5_product", product, 32'h0001_0000);
`ifdef MUL_OVF_EN
    check_eq("t5_ovf", ovf, 1);
`endif
    @(negedge clk);

    // Back-to-back with start held high
    begin
      int idx;
      int cyc;
      int last_done;
      bit prev_done;
      idx       = 0;
      last_done = 0;
      prev_done = 1'b0;
      start     = 1'b1;
      a         = b2b_a[0];
      b         = b2b_b[0];
      for (cyc = 0; cyc < 100 && idx < 3; cyc++) begin
        @(negedge clk);
        if (prev_done) begin
          check_eq("b2b_done_single", done, 0);
          check_eq("b2b_busy_gap", busy, 0);
        end
        prev_done = done;
        if (done) begin
          check_eq($sformatf("b2b_product_%0d", idx), product, b2b_exp[idx]);
          if (idx > 0) check_eq($sformatf("b2b_period_%0d", idx), cyc - last_done, 18);
          last_done = cyc;
          idx++;
          if (idx < 3) begin
            a = b2b_a[idx];
            b = b2b_b[idx];
          end
        end
      end
      check_eq("b2b_ops_completed", idx, 3);
      start = 1'b0;
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
